// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes are queued through a write strobe into
// a small FIFO and serialised LSB first onto tx with no idle gap between
// consecutive frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_baud;
    logic [15:0]     w_baud_next;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            r_busy;
    logic            w_busy_next;
    logic            r_done;
    logic            w_done_next;
    logic            r_ovf;
    logic            w_pop;
    logic            w_wr_ok;
    logic            w_full;
    logic            w_empty;
    logic            w_baud_zero;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [7:0]      r_mem [FIFO_DEPTH];

    // Status flags come only from the registered count, so they lag a write/pop by one cycle.
    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_wr_ok     = wr_en & ~w_full;
    assign w_baud_zero = (r_baud == 16'd0);

    assign full    = w_full;
    assign empty   = w_empty;
    assign ovf     = r_ovf;
    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // FIFO storage; contents need no reset because count/pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy count and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= wr_en & w_full;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State register plus the control counters and registered outputs that advance with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Shift register holds the byte in flight; it is only meaningful once loaded by a pop.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_next;
    end

    // Next-state logic: pops the FIFO from IDLE or straight out of the last stop cycle.
    always_comb begin
        w_next_state = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_baud_next  = BAUD_LOAD;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_baud_zero) begin
                    w_baud_next  = BAUD_LOAD;
                    w_bit_next   = 3'd0;
                    w_next_state = S_DATA;
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_zero) begin
                    w_baud_next  = BAUD_LOAD;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_next_state = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_zero) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_baud_next  = BAUD_LOAD;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output logic: tx/busy are computed from the upcoming state so the pins come straight off flops.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_next_state != S_IDLE);
        // Done is raised one edge early so it is high during the final stop cycle.
        w_done_next = (r_state == S_STOP) && (r_baud == 16'd1);
        case (w_next_state)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: cycle-by-cycle comparison against a frame-level
// reference model built from a byte queue and a frame countdown.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int n_ovf  = 0;

    // Reference model state.
    logic [7:0] m_q[$];
    int         m_left;
    logic [7:0] m_cur;
    logic       m_ovf;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .ovf    (ovf),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_left = 0;
        m_cur  = 8'h00;
        m_ovf  = 1'b0;
    endfunction

    // One clock edge of the model: a frame lasts FRAME cycles, a new one may start
    // when the line is idle or on the edge that ends the previous stop bit.
    function automatic void model_edge(input logic w, input logic [7:0] d);
        int  pre;
        bit  pop;
        pre   = m_q.size();
        pop   = (pre > 0) && (m_left <= 1);
        m_ovf = w && (pre == DEPTH);
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_left = FRAME;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (w && pre < DEPTH) m_q.push_back(d);
    endfunction

    function automatic logic model_tx();
        int el;
        int b;
        if (m_left == 0) return 1'b1;
        el = FRAME - m_left;
        b  = el / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic compare_all();
        check_eq("tx",      32'(tx),      32'(model_tx()));
        check_eq("tx_busy", 32'(tx_busy), 32'(m_left > 0));
        check_eq("tx_done", 32'(tx_done), 32'(m_left == 1));
        check_eq("full",    32'(full),    32'(m_q.size() == DEPTH));
        check_eq("empty",   32'(empty),   32'(m_q.size() == 0));
        check_eq("ovf",     32'(ovf),     32'(m_ovf));
    endtask

    // Called at a falling edge: apply inputs, advance one clock, compare at the next falling edge.
    task automatic step(input logic w, input logic [7:0] d);
        wr_en   = w;
        wr_data = d;
        @(posedge clk);
        if (rst_n) model_edge(w, d);
        else       model_reset();
        @(negedge clk);
        if (ovf) n_ovf++;
        compare_all();
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Single byte.
        step(1'b1, 8'hA5);
        idle(FRAME + 10);

        // Back-to-back frames.
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h3C);
        idle(3 * FRAME + 10);

        // Overflow with the transmitter held busy.
        step(1'b1, 8'hE7);
        idle(5);
        n_ovf = 0;
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i));
        check_eq("ovf_count", 32'(n_ovf), 32'd2);
        idle(9 * FRAME + 10);

        // Write on the final stop-cycle edge while one byte is queued.
        step(1'b1, 8'h3A);
        step(1'b1, 8'hC5);
        for (int k = 0; k < 2 * FRAME && m_left != 1; k++) step(1'b0, 8'h00);
        step(1'b1, 8'h77);
        check_eq("simul_count", 32'(empty), 32'd0);
        idle(2 * FRAME + 20);

        // Asynchronous reset during data bit 3 of 0x55 with two bytes queued.
        step(1'b1, 8'h55);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        for (int k = 0; k < 2 * FRAME && m_left != FRAME - (4 * CPB + CPB / 2); k++)
            step(1'b0, 8'h00);
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_tx",    32'(tx),      32'd1);
        check_eq("rst_busy",  32'(tx_busy), 32'd0);
        check_eq("rst_empty", 32'(empty),   32'd1);
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(3 * FRAME);

        // Randomised traffic alternating bursty and sparse phases.
        for (int k = 0; k < 4000; k++) begin
            int pct;
            pct = ((k / 500) % 2 == 0) ? 40 : 3;
            step(($urandom_range(0, 99) < pct), 8'($urandom));
        end
        idle((DEPTH + 1) * FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
